aig_seq_eval: RTL and testbench

Parametrised sequential And-Inverter-Graph evaluator. Holds a runtime-programmable AIG of up to MAX_NODES two-input AND nodes with complemented edges, and evaluates it one node per clock. It runs either for a single input vector or for a full truth-table sweep over all 2^NUM_IN input patterns. It sits beside the fixed combinational 4-input NPN-class netlists and replaces any of them without resynthesis by loading the node list at runtime.

---
 rtl/aig_seq_eval.sv | 206 ++++++++++++++++++++
 tb/tb_aig_seq_eval.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/aig_seq_eval.sv
// aig_seq_eval: sequential And-Inverter-Graph evaluator.
// Holds a runtime-loaded AIG of up to MAX_NODES two-input AND nodes with complemented edges.
// It evaluates one node per clock, either for one input vector (mode 0) or as a full
// truth-table sweep over all 2^NUM_IN input patterns (mode 1).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   cfg_op/cfg_we       config op: 0 write node, 1 write output literal, 2 write count, 3 nop
//   cfg_addr            node index for op 0
//   cfg_lit0/cfg_lit1   fanin literals (op 0); output literal (op 1); node count (op 2)
//   start, mode, x      start request, 0 single vector / 1 sweep, input vector (mode 0)
//   busy, done          evaluation in progress, one-cycle completion pulse
//   y, tt               function result, truth table (bit p = result for pattern p)
module aig_seq_eval #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned MAX_NODES = 16,
  localparam int unsigned NV = 1 + NUM_IN + MAX_NODES,
  localparam int unsigned LW = $clog2(2 * NV),
  localparam int unsigned AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
  localparam int unsigned NP = 1 << NUM_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_op,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [LW-1:0]     cfg_lit0,
  input  logic [LW-1:0]     cfg_lit1,
  input  logic              start,
  input  logic              mode,
  input  logic [NUM_IN-1:0] x,
  output logic              busy,
  output logic              done,
  output logic              y,
  output logic [NP-1:0]     tt
);

  localparam int unsigned CW = $clog2(MAX_NODES + 1);
  localparam int unsigned VW = LW - 1;

  typedef enum logic [1:0] {StIdle, StLoad, StEval, StOut} state_e;

  state_e              state_q, state_d;
  logic [LW-1:0]       lit0_q [MAX_NODES];
  logic [LW-1:0]       lit0_d [MAX_NODES];
  logic [LW-1:0]       lit1_q [MAX_NODES];
  logic [LW-1:0]       lit1_d [MAX_NODES];
  logic [LW-1:0]       out_lit_q, out_lit_d;
  logic [CW-1:0]       n_q, n_d;
  logic [MAX_NODES-1:0] node_val_q, node_val_d;
  logic [NUM_IN-1:0]   in_q, in_d;
  logic [NUM_IN-1:0]   x_q, x_d;
  logic [NUM_IN-1:0]   pat_q, pat_d;
  logic                mode_q, mode_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                done_q, done_d;
  logic                y_q, y_d;
  logic [NP-1:0]       tt_q, tt_d;

  logic [NV-1:0]       var_val;
  logic                cfg_ok;
  logic                last_node;
  logic                out_res;

  // Variable value vector in literal order: const 0, inputs, then nodes.
  assign var_val = {node_val_q, in_q, 1'b0};

  // Vars beyond NV yield 0 regardless of the complement bit.
  function automatic logic lit_val(input logic [LW-1:0] lit, input logic [NV-1:0] vals);
    logic r;
    r = 1'b0;
    for (int unsigned v = 0; v < NV; v++) begin
      if (lit[LW-1:1] == VW'(v)) r = vals[v] ^ lit[0];
    end
    return r;
  endfunction

  assign cfg_ok    = cfg_we && (state_q == StIdle) && !done_q;
  assign last_node = (ptr_q == AW'(n_q - CW'(1)));
  assign out_res   = lit_val(out_lit_q, var_val);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: state_d = (n_q == '0) ? StOut : StEval;
      StEval: if (last_node) state_d = StOut;
      StOut:  state_d = (mode_q && (pat_q != '1)) ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (state_q != StIdle);
    done = done_q;
    y    = y_q;
    tt   = tt_q;
  end

  // Datapath and program storage next-state.
  always_comb begin
    lit0_d     = lit0_q;
    lit1_d     = lit1_q;
    out_lit_d  = out_lit_q;
    n_d        = n_q;
    node_val_d = node_val_q;
    in_d       = in_q;
    x_d        = x_q;
    pat_d      = pat_q;
    mode_d     = mode_q;
    ptr_d      = ptr_q;
    done_d     = 1'b0;
    y_d        = y_q;
    tt_d       = tt_q;

    if (cfg_ok) begin
      unique case (cfg_op)
        2'd0: begin
          if (32'(cfg_addr) < MAX_NODES) begin
            lit0_d[cfg_addr] = cfg_lit0;
            lit1_d[cfg_addr] = cfg_lit1;
          end
        end
        2'd1: out_lit_d = cfg_lit0;
        2'd2: n_d = (32'(cfg_lit0) > MAX_NODES) ? CW'(MAX_NODES) : CW'(cfg_lit0);
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d = mode;
          x_d    = x;
          pat_d  = '0;
        end
      end
      StLoad: begin
        // Clearing node values makes forward and self references read 0.
        node_val_d = '0;
        in_d       = mode_q ? pat_q : x_q;
        ptr_d      = '0;
      end
      StEval: begin
        node_val_d[ptr_q] = lit_val(lit0_q[ptr_q], var_val) & lit_val(lit1_q[ptr_q], var_val);
        ptr_d             = ptr_q + AW'(1);
      end
      StOut: begin
        if (!mode_q) begin
          y_d    = out_res;
          done_d = 1'b1;
        end else begin
          tt_d[pat_q] = out_res;
          if (pat_q != '1) begin
            pat_d = pat_q + NUM_IN'(1);
          end else begin
            y_d    = out_res;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lit0_q     <= '{default: '0};
      lit1_q     <= '{default: '0};
      out_lit_q  <= '0;
      n_q        <= '0;
      node_val_q <= '0;
      in_q       <= '0;
      x_q        <= '0;
      pat_q      <= '0;
      mode_q     <= 1'b0;
      ptr_q      <= '0;
      done_q     <= 1'b0;
      y_q        <= 1'b0;
      tt_q       <= '0;
    end else begin
      lit0_q     <= lit0_d;
      lit1_q     <= lit1_d;
      out_lit_q  <= out_lit_d;
      n_q        <= n_d;
      node_val_q <= node_val_d;
      in_q       <= in_d;
      x_q        <= x_d;
      pat_q      <= pat_d;
      mode_q     <= mode_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      y_q        <= y_d;
      tt_q       <= tt_d;
    end
  end

endmodule

// File: tb/tb_aig_seq_eval.sv
// Directed self-checking bench for aig_seq_eval (NUM_IN=4, MAX_NODES=16).
module tb_aig_seq_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_op;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [5:0]  cfg_lit0;
  logic [5:0]  cfg_lit1;
  logic        start;
  logic        mode;
  logic [3:0]  x;
  logic        busy;
  logic        done;
  logic        y;
  logic [15:0] tt;

  int checks = 0;
  int passed = 0;
  int cyc;
  int seen;

  aig_seq_eval #(
    .NUM_IN   (4),
    .MAX_NODES(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_op  (cfg_op),
    .cfg_we  (cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_lit0(cfg_lit0),
    .cfg_lit1(cfg_lit1),
    .start   (start),
    .mode    (mode),
    .x       (x),
    .busy    (busy),
    .done    (done),
    .y       (y),
    .tt      (tt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // All drivers are called at a falling edge and return at a falling edge.
  task automatic cfg(input logic [1:0] op, input logic [3:0] addr, input logic [5:0] l0,
                     input logic [5:0] l1);
    cfg_op = op; cfg_addr = addr; cfg_lit0 = l0; cfg_lit1 = l1; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; cfg_op = 2'd3;
  endtask

  task automatic kick(input logic m, input logic [3:0] xv);
    start = 1'b1; mode = m; x = xv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done; returns at the falling edge where done is high.
  task automatic wait_done(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 2000) begin
      if (busy === 1'b1) n++;
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0; cfg_op = 2'd3;
      guard++;
    end
  endtask

  task automatic load_xor();
    cfg(2'd2, 4'd0, 6'd3, 6'd0);
    cfg(2'd0, 4'd0, 6'd2, 6'd5);
    cfg(2'd0, 4'd1, 6'd3, 6'd4);
    cfg(2'd0, 4'd2, 6'd11, 6'd13);
    cfg(2'd1, 4'd0, 6'd15, 6'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_op = 2'd3; cfg_we = 1'b0; cfg_addr = '0; cfg_lit0 = '0; cfg_lit1 = '0;
    start = 1'b0; mode = 1'b0; x = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_y", y, 0);
    check("reset_tt", tt, 0);
    rst = 1'b0;
    @(negedge clk);

    // XOR(x0,x1), single vector
    load_xor();
    kick(1'b0, 4'b0001);
    wait_done(cyc);
    check("xor01_done", done, 1);
    check("xor01_busy_at_done", busy, 0);
    check("xor01_cycles", cyc, 5);
    check("xor01_y", y, 1);
    check("xor01_tt_untouched", tt, 16'h0000);
    // start in the done cycle is accepted
    kick(1'b0, 4'b0011);
    check("restart_busy", busy, 1);
    check("restart_done_pulse", done, 0);
    wait_done(cyc);
    check("xor11_cycles", cyc, 5);
    check("xor11_y", y, 0);

    // config write in the cycle after done is accepted: out literal becomes XNOR
    @(negedge clk);
    cfg(2'd1, 4'd0, 6'd14, 6'd0);
    kick(1'b0, 4'b0011);
    wait_done(cyc);
    check("xnor11_y", y, 1);
    @(negedge clk);
    cfg(2'd1, 4'd0, 6'd15, 6'd0);

    // truth-table sweep
    kick(1'b1, 4'b0000);
    wait_done(cyc);
    check("sweep_cycles", cyc, 80);
    check("sweep_tt", tt, 16'h6666);
    check("sweep_y", y, 0);

    // config and start while busy are ignored
    @(negedge clk);
    kick(1'b0, 4'b0001);
    cfg_op = 2'd1; cfg_lit0 = 6'd0; cfg_we = 1'b1; start = 1'b1; mode = 1'b1; x = 4'b0000;
    wait_done(cyc);
    check("busy_ign_cycles", cyc, 5);
    check("busy_ign_y", y, 1);
    check("busy_ign_tt", tt, 16'h6666);
    kick(1'b0, 4'b0011);
    wait_done(cyc);
    check("busy_ign_outlit_kept", y, 0);

    // forward reference reads 0
    @(negedge clk);
    cfg(2'd2, 4'd0, 6'd2, 6'd0);
    cfg(2'd0, 4'd0, 6'd12, 6'd2);
    cfg(2'd0, 4'd1, 6'd2, 6'd2);
    cfg(2'd1, 4'd0, 6'd10, 6'd0);
    kick(1'b0, 4'b0001);
    wait_done(cyc);
    check("fwd_cycles", cyc, 4);
    check("fwd_y", y, 0);

    // constant 1 with no nodes
    @(negedge clk);
    cfg(2'd2, 4'd0, 6'd0, 6'd0);
    cfg(2'd1, 4'd0, 6'd1, 6'd0);
    kick(1'b1, 4'b0000);
    wait_done(cyc);
    check("const_sweep_cycles", cyc, 32);
    check("const_sweep_tt", tt, 16'hFFFF);
    check("const_sweep_y", y, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    kick(1'b0, 4'b1010);
    wait_done(cyc);
    check("const_single_cycles", cyc, 2);
    check("const_single_y", y, 1);
    check("const_single_tt", tt, 16'hFFFF);

    // node count above MAX_NODES clamps to 16
    @(negedge clk);
    cfg(2'd2, 4'd0, 6'd40, 6'd0);
    kick(1'b0, 4'b0000);
    wait_done(cyc);
    check("clamp_cycles", cyc, 18);

    // reset mid-sweep aborts and clears the program
    @(negedge clk);
    kick(1'b1, 4'b0000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_tt", tt, 0);
    check("abort_y", y, 0);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    kick(1'b0, 4'b0001);
    wait_done(cyc);
    check("cleared_prog_cycles", cyc, 2);
    check("cleared_prog_y", y, 0);
    @(negedge clk);
    load_xor();
    kick(1'b0, 4'b0001);
    wait_done(cyc);
    check("reload_cycles", cyc, 5);
    check("reload_y", y, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
